// File: rtl/mips32_pkg.sv
// Shared MIPS32 datapath definitions: default data width and the skid buffer occupancy state.
package mips32_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready buffer: 1-cycle latency, full throughput, registered in_ready.
module skid_buf_2
  import mips32_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         accept;
  logic         pop;

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head      <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid     <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop && !accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (accept && pop) begin
            head <= in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the skid entry forward
          if (pop) begin
            head     <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_mux_n.sv
// Registered NUM_IN:1 operand select with range flag, behind a 2-entry valid/ready skid buffer.
module reg_mux_n
  import mips32_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int BUF_W = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;

  // Extra bit so NUM_IN == 2**SEL_W still compares correctly
  assign sel_err = ({1'b0, in_sel} >= (SEL_W + 1)'(NUM_IN));

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign buf_in = {sel_err, in_sel, sel_word};

  skid_buf_2 #(
    .W (BUF_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (buf_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data = buf_out[WIDTH-1:0];
  assign out_sel  = buf_out[WIDTH +: SEL_W];
  assign out_err  = buf_out[BUF_W-1];

endmodule
